cpu_run_ctrl: RTL and testbench

Parametrised run/debug controller for the multi-cycle CPU top level. It replaces the free-running clock/reset stimulus with a managed reset sequence, a core clock-enable, and RUN/STEP/HALT modes. It also provides PC breakpoint, halt-opcode detection, a cycle-limit watchdog, and cycle and retired-instruction counters. It sits between board buttons or bench stimulus and the core's enable and reset inputs, and observes the core's PC, opcode and PCWre.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/sat_counter.sv | 23 ++
 rtl/cpu_run_ctrl.sv | 134 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU run/debug controller: FSM states, halt reasons
// and the opcode field width.
package cpu_pkg;

    localparam int unsigned      OP_W        = 6;
    localparam logic [OP_W-1:0] HALT_OP_DEF = 6'b111111;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_PAUSED   = 3'd1,
        ST_RUN      = 3'd2,
        ST_STEP     = 3'd3,
        ST_HALTED   = 3'd4
    } run_state_t;

    typedef enum logic [2:0] {
        HR_NONE   = 3'd0,
        HR_USER   = 3'd1,
        HR_BP     = 3'd2,
        HR_HALTOP = 3'd3,
        HR_WDOG   = 3'd4
    } halt_reason_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear,
// asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/debug controller for the multi-cycle CPU: reset sequencing, core clock
// enable, RUN/STEP/HALT modes, breakpoint, halt opcode, watchdog and counters.
module cpu_run_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned      ADDR_W     = 32,
    parameter int unsigned      CNT_W      = 32,
    parameter int unsigned      RST_CYCLES = 4,
    parameter logic [OP_W-1:0] HALT_OP    = HALT_OP_DEF,
    parameter int unsigned      MAX_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic [OP_W-1:0]   op,
    input  logic              pc_wre,
    output logic              core_rst,
    output logic              core_en,
    output logic [2:0]        state,
    output logic [2:0]        halt_reason,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int unsigned       HOLD_W    = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WDOG_LAST = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

    run_state_t        cur;
    halt_reason_t      reason;
    logic [HOLD_W-1:0] hold_cnt;
    logic              user_pend;
    logic              at_fetch;
    logic              boundary;
    logic              user_halt;
    logic              bp_hit;
    logic              op_hit;
    logic              wdog_hit;

    // RUN and STEP are the only encodings with bit 1 set, so the enable is a
    // single flop output and cannot glitch.
    assign core_en     = cur[1];
    assign state       = cur;
    assign halt_reason = reason;

    assign boundary  = core_en && pc_wre;
    assign user_halt = user_pend || halt_req;
    assign bp_hit    = bp_en && (pc == bp_addr);
    assign op_hit    = (op == HALT_OP);
    assign wdog_hit  = (MAX_CYCLES != 0) && core_en && (cycle_cnt >= WDOG_LAST);

    // PC only shows the next instruction after the retiring edge, so the
    // breakpoint is tested on the first cycle of each instruction (at_fetch).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur       <= ST_RST_HOLD;
            reason    <= HR_NONE;
            hold_cnt  <= '0;
            user_pend <= 1'b0;
            at_fetch  <= 1'b0;
            core_rst  <= 1'b1;
        end else begin
            if (boundary) begin
                user_pend <= 1'b0;
                at_fetch  <= 1'b1;
            end else if (core_en) begin
                at_fetch <= 1'b0;
                if (halt_req) user_pend <= 1'b1;
            end

            case (cur)
                ST_RST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        cur      <= ST_PAUSED;
                        core_rst <= 1'b0;
                        at_fetch <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_PAUSED: begin
                    if (step_req || run_req) begin
                        if (bp_hit) begin
                            cur    <= ST_HALTED;
                            reason <= HR_BP;
                        end else begin
                            cur <= step_req ? ST_STEP : ST_RUN;
                        end
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (wdog_hit) begin
                        cur    <= ST_HALTED;
                        reason <= HR_WDOG;
                    end else if (boundary && op_hit) begin
                        cur    <= ST_HALTED;
                        reason <= HR_HALTOP;
                    end else if (at_fetch && bp_hit) begin
                        cur    <= ST_HALTED;
                        reason <= HR_BP;
                    end else if (boundary && user_halt) begin
                        cur    <= ST_HALTED;
                        reason <= HR_USER;
                    end else if (boundary && ((cur == ST_STEP) || !run_req)) begin
                        cur <= ST_PAUSED;
                    end
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clear (cur == ST_RST_HOLD),
        .inc   (core_en),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clear (cur == ST_RST_HOLD),
        .inc   (boundary),
        .count (retire_cnt)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a 4-cycle-per-instruction core model drives pc/pc_wre;
// expectations are queued with the stimulus and drained against the outputs.
module tb_cpu_run_ctrl;
    import cpu_pkg::*;

    logic        CLK;
    logic        RST;
    logic        run_req, step_req, halt_req, bp_en;
    logic [31:0] bp_addr, pc;
    logic [5:0]  op;
    logic        pc_wre;
    logic        core_rst, core_en;
    logic [2:0]  state, halt_reason;
    logic [31:0] cycle_cnt, retire_cnt;

    logic        run_wd;
    logic        wd_core_rst, wd_core_en;
    logic [2:0]  wd_state, wd_reason;
    logic [31:0] wd_cyc, wd_ret;

    logic        run_sat;
    logic        t_core_rst, t_core_en;
    logic [2:0]  t_state, t_reason;
    logic [2:0]  t_cyc, t_ret;

    logic [1:0]  phase;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    cpu_run_ctrl dut (
        .CLK(CLK), .RST(RST), .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .op(op), .pc_wre(pc_wre), .core_rst(core_rst), .core_en(core_en),
        .state(state), .halt_reason(halt_reason), .cycle_cnt(cycle_cnt),
        .retire_cnt(retire_cnt)
    );

    cpu_run_ctrl #(.MAX_CYCLES(10)) dut_wd (
        .CLK(CLK), .RST(RST), .run_req(run_wd), .step_req(1'b0),
        .halt_req(1'b0), .bp_en(1'b0), .bp_addr(32'd0), .pc(32'd0),
        .op(6'd0), .pc_wre(1'b0), .core_rst(wd_core_rst), .core_en(wd_core_en),
        .state(wd_state), .halt_reason(wd_reason), .cycle_cnt(wd_cyc),
        .retire_cnt(wd_ret)
    );

    cpu_run_ctrl #(.CNT_W(3)) dut_sat (
        .CLK(CLK), .RST(RST), .run_req(run_sat), .step_req(1'b0),
        .halt_req(1'b0), .bp_en(1'b0), .bp_addr(32'd0), .pc(32'd0),
        .op(6'd0), .pc_wre(1'b1), .core_rst(t_core_rst), .core_en(t_core_en),
        .state(t_state), .halt_reason(t_reason), .cycle_cnt(t_cyc),
        .retire_cnt(t_ret)
    );

    // Core model: every instruction takes 4 enabled cycles, retiring on the 4th.
    always_ff @(posedge CLK) begin
        if (core_rst) begin
            phase <= 2'd0;
            pc    <= 32'd0;
        end else if (core_en) begin
            if (phase == 2'd3) begin
                phase <= 2'd0;
                pc    <= pc + 32'd4;
            end else begin
                phase <= phase + 2'd1;
            end
        end
    end
    assign pc_wre = (phase == 2'd3);

    localparam int S_STATE = 0, S_RST = 1, S_EN = 2, S_REASON = 3, S_CYC = 4,
                   S_RET = 5, S_PC = 6, W_STATE = 7, W_REASON = 8, W_CYC = 9,
                   W_EN = 10, T_CYC = 11, T_RET = 12, T_STATE = 13;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_STATE:  return {29'd0, state};
            S_RST:    return {31'd0, core_rst};
            S_EN:     return {31'd0, core_en};
            S_REASON: return {29'd0, halt_reason};
            S_CYC:    return cycle_cnt;
            S_RET:    return retire_cnt;
            S_PC:     return pc;
            W_STATE:  return {29'd0, wd_state};
            W_REASON: return {29'd0, wd_reason};
            W_CYC:    return wd_cyc;
            W_EN:     return {31'd0, wd_core_en};
            T_CYC:    return {29'd0, t_cyc};
            T_RET:    return {29'd0, t_ret};
            T_STATE:  return {29'd0, t_state};
            default:  return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic wait_for(input string tag, input int sel, input logic [31:0] want, input int budget);
        int n = 0;
        while ((observe(sel) !== want) && (n < budget)) begin
            @(posedge CLK); #1;
            n++;
        end
        if (observe(sel) !== want) check_eq({tag, "_timeout"}, observe(sel), want);
    endtask

    task automatic release_reset(input string tag);
        int n = 0;
        @(negedge CLK);
        RST = 1'b0;
        while ((core_rst === 1'b1) && (n < 20)) begin
            @(posedge CLK); #1;
            n++;
        end
        check_eq({tag, "_hold_cycles"}, n, 32'd4);
        expect_val({tag, "_state"}, S_STATE, 32'd1);
        expect_val({tag, "_en"}, S_EN, 32'd0);
        expect_val({tag, "_cyc"}, S_CYC, 32'd0);
        expect_val({tag, "_ret"}, S_RET, 32'd0);
        drain();
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        RST = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        bp_en = 1'b0; bp_addr = 32'd0; op = 6'd0; run_wd = 1'b0; run_sat = 1'b0;
        #12;

        // Reset values and hold sequence
        expect_val("rst_state", S_STATE, 32'd0);
        expect_val("rst_core_rst", S_RST, 32'd1);
        expect_val("rst_en", S_EN, 32'd0);
        expect_val("rst_reason", S_REASON, 32'd0);
        expect_val("rst_cyc", S_CYC, 32'd0);
        expect_val("rst_ret", S_RET, 32'd0);
        drain();
        release_reset("t1");

        // Single step of one 4-cycle instruction
        step_req = 1'b1;
        @(posedge CLK); #1;
        step_req = 1'b0;
        n = 0;
        while ((core_en === 1'b1) && (n < 20)) begin
            n++;
            @(posedge CLK); #1;
        end
        check_eq("t2_en_cycles", n, 32'd4);
        expect_val("t2_ret", S_RET, 32'd1);
        expect_val("t2_cyc", S_CYC, 32'd4);
        expect_val("t2_state", S_STATE, 32'd1);
        expect_val("t2_pc", S_PC, 32'h4);
        drain();

        // Breakpoint at 0x10: instructions at 4, 8, C retire, plus the fetch
        // cycle of 0x10 on which the breakpoint is seen -> 4 + 12 + 1 cycles.
        bp_en = 1'b1; bp_addr = 32'h10; run_req = 1'b1;
        expect_val("t3_state", S_STATE, 32'd4);
        expect_val("t3_reason", S_REASON, 32'd2);
        expect_val("t3_pc", S_PC, 32'h10);
        expect_val("t3_en", S_EN, 32'd0);
        expect_val("t3_ret", S_RET, 32'd4);
        expect_val("t3_cyc", S_CYC, 32'd17);
        wait_for("t3", S_STATE, 32'd4, 40);
        drain();

        // Halt opcode wins over a pending user halt at the same boundary
        run_req = 1'b0; bp_en = 1'b0;
        pulse_reset();
        release_reset("t4");
        run_req = 1'b1;
        @(posedge CLK); #1;
        halt_req = 1'b1; op = 6'b111111;
        @(posedge CLK); #1;
        halt_req = 1'b0;
        expect_val("t4_reason", S_REASON, 32'd3);
        expect_val("t4_ret", S_RET, 32'd1);
        expect_val("t4_cyc", S_CYC, 32'd4);
        wait_for("t4", S_STATE, 32'd4, 20);
        drain();
        op = 6'd0;
        step_req = 1'b1;
        @(posedge CLK); #1;
        step_req = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        expect_val("t4_halted_state", S_STATE, 32'd4);
        expect_val("t4_halted_en", S_EN, 32'd0);
        expect_val("t4_halted_cyc", S_CYC, 32'd4);
        expect_val("t4_halted_reason", S_REASON, 32'd3);
        drain();

        // run_req drop pauses at the boundary; then a user halt
        run_req = 1'b0;
        pulse_reset();
        release_reset("t4b");
        run_req = 1'b1;
        @(posedge CLK); #1;
        run_req = 1'b0;
        @(posedge CLK); #1;
        expect_val("pause_reason", S_REASON, 32'd0);
        expect_val("pause_ret", S_RET, 32'd1);
        expect_val("pause_cyc", S_CYC, 32'd4);
        wait_for("pause", S_STATE, 32'd1, 20);
        drain();
        run_req = 1'b1;
        @(posedge CLK); #1;
        halt_req = 1'b1;
        @(posedge CLK); #1;
        halt_req = 1'b0;
        expect_val("user_reason", S_REASON, 32'd1);
        expect_val("user_ret", S_RET, 32'd2);
        expect_val("user_cyc", S_CYC, 32'd8);
        wait_for("user", S_STATE, 32'd4, 20);
        drain();

        // Watchdog at 10 cycles (no retirements) and 3-bit counter saturation
        run_req = 1'b0;
        pulse_reset();
        release_reset("t5");
        run_wd = 1'b1; run_sat = 1'b1;
        expect_val("t5_wd_cyc", W_CYC, 32'd10);
        expect_val("t5_wd_reason", W_REASON, 32'd4);
        expect_val("t5_wd_en", W_EN, 32'd0);
        wait_for("t5", W_STATE, 32'd4, 40);
        drain();
        repeat (10) @(posedge CLK);
        #1;
        expect_val("sat_cyc", T_CYC, 32'd7);
        expect_val("sat_ret", T_RET, 32'd7);
        expect_val("sat_state", T_STATE, 32'd2);
        drain();

        // Asynchronous reset in the middle of a run
        run_wd = 1'b0; run_sat = 1'b0;
        pulse_reset();
        release_reset("t6a");
        run_req = 1'b1;
        wait_for("t6_run", S_CYC, 32'd7, 30);
        #2;
        RST = 1'b1;
        #1;
        expect_val("t6_state", S_STATE, 32'd0);
        expect_val("t6_core_rst", S_RST, 32'd1);
        expect_val("t6_en", S_EN, 32'd0);
        expect_val("t6_reason", S_REASON, 32'd0);
        expect_val("t6_cyc", S_CYC, 32'd0);
        expect_val("t6_ret", S_RET, 32'd0);
        drain();
        run_req = 1'b0;
        release_reset("t6b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
